// File: rtl/raifes_hasti_master_pkg.sv
// Shared AHB-lite (HASTI) encodings, command record and small helpers
// for the single-outstanding bus initiator.
package raifes_hasti_master_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lsb[0];
            HSIZE_WORD: ok = (addr_lsb == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Right-aligned write data copied onto every byte lane the size covers.
    function automatic logic [DATA_W-1:0] lane_replicate(input logic [DATA_W-1:0] wdata,
                                                         input logic [2:0]        size);
        logic [DATA_W-1:0] r;
        case (size)
            HSIZE_BYTE: r = {4{wdata[7:0]}};
            HSIZE_HALF: r = {2{wdata[15:0]}};
            default:    r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/raifes_hasti_master_wait_timer.sv
// Wait-state counter: counts enabled cycles since clear and flags the cycle
// in which the limit-th enabled cycle occurs. A limit of zero never expires.
module raifes_wait_timer #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && !clear_i && (limit_i != '0)
                       && (count_q == (limit_i - WIDTH'(1)));

endmodule

// File: rtl/raifes_hasti_master.sv
// Single-outstanding AHB-lite initiator: one SINGLE/NONSEQ transfer per
// command, with wait-state timeout and a valid/ready response port.
module raifes_hasti_master
    import raifes_hasti_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic              hmastlock,
    output logic [3:0]        hprot,
    output logic [1:0]        htrans,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_DRAIN
    } state_e;

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic              timer_clear;
    logic              timer_en;
    logic              timer_expired;

    assign timer_en = ((state_q == S_ADDR) || (state_q == S_DATA)) && !hready;

    raifes_wait_timer #(
        .WIDTH (TIMER_W)
    ) u_wait_timer (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .limit_i   (TIMER_W'(TIMEOUT_CYCLES)),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        timer_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_d   = '{addr: cmd_addr, write: cmd_write, size: cmd_size, wdata: cmd_wdata};
                    rdata_d = '0;
                    tmo_d   = 1'b0;
                    if (cmd_legal(cmd_size, cmd_addr[1:0])) begin
                        err_d       = 1'b0;
                        timer_clear = 1'b1;
                        state_d     = S_ADDR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (timer_expired) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_DRAIN;
                end else if (hready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (timer_expired) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_DRAIN;
                end else if (hready) begin
                    // ERROR's first cycle has hready low and simply waits here.
                    if (hresp == HRESP_ERROR) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (hresp == HRESP_OKAY && !cmd_q.write) begin
                        rdata_d = hrdata;
                    end
                    state_d = S_RESP;
                end
            end
            S_DRAIN: begin
                if (hready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE) && reset;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;

    assign htrans    = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr     = cmd_q.addr;
    assign hwrite    = cmd_q.write;
    assign hsize     = cmd_q.size;
    assign hburst    = HBURST_SINGLE;
    assign hmastlock = 1'b0;
    assign hprot     = HPROT_VAL;
    assign hwdata    = lane_replicate(cmd_q.wdata, cmd_q.size);

endmodule
